// File: rtl/gcm_icb_sequencer.sv
// gcm_icb_sequencer
//   Generates the GCM counter-block stream for the AES core in 96-bit-IV
//   mode. A start command latches the IV and block count. The block emits
//   J0 = IV||32'd1 first, which becomes the tag mask, and then iNumBlk data
//   counter blocks IV||ctr. ctr starts at 2 and is advanced with inc32.
//
// Ports
//   iClk       clock; all logic on the rising edge
//   iRst       synchronous reset, active-high
//   iStart     start pulse, honoured only in IDLE
//   iAbort     synchronous abort back to IDLE, with no done pulse
//   iIV        96-bit IV, sampled when a start is accepted
//   iNumBlk    number of data blocks that follow J0
//   oCB        counter block {IV, ctr}, MSB-first
//   oCB_valid  oCB is offered to the AES core
//   iCB_ready  AES core takes oCB this cycle
//   oIsJ0      the offered block is J0
//   oLast      the offered block is the final block of the message
//   oBusy      sequence in progress (J0 or DATA)
//   oDone      one-cycle pulse after the final block has been accepted
//   oWrap      sticky flag: ctr wrapped from all-ones to zero in this message
module gcm_icb_sequencer #(
  parameter int IV_W  = 96,
  parameter int CTR_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic [0:IV_W-1]  iIV,
  input  logic [LEN_W-1:0] iNumBlk,
  output logic [0:127]     oCB,
  output logic             oCB_valid,
  input  logic             iCB_ready,
  output logic             oIsJ0,
  output logic             oLast,
  output logic             oBusy,
  output logic             oDone,
  output logic             oWrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    J0   = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [0:IV_W-1]  ivReg;
  logic [CTR_W-1:0] ctr;
  logic [LEN_W-1:0] remCnt;    // data blocks still to be issued
  logic             wrapReg;
  logic             xfer;
  logic             startOk;

  // The handshake is derived from the state, not from oCB_valid. This keeps
  // the next-state logic free of a combinational loop through its own output.
  assign xfer    = iCB_ready & ((state == J0) | (state == DATA));
  assign startOk = (state == IDLE) & iStart & ~iAbort;

  assign oCB   = {ivReg, ctr};
  assign oWrap = wrapReg;

  always_comb begin
    stateNext = state;
    oCB_valid = 1'b0;
    oIsJ0     = 1'b0;
    oLast     = 1'b0;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    unique case (state)
      IDLE: begin
        if (startOk) stateNext = J0;
      end
      J0: begin
        oCB_valid = 1'b1;
        oIsJ0     = 1'b1;
        oBusy     = 1'b1;
        oLast     = (remCnt == '0);
        if (iAbort)    stateNext = IDLE;
        else if (xfer) stateNext = (remCnt == '0) ? DONE : DATA;
      end
      DATA: begin
        oCB_valid = 1'b1;
        oBusy     = 1'b1;
        oLast     = (remCnt == LEN_W'(1));
        if (iAbort)                              stateNext = IDLE;
        else if (xfer && remCnt == LEN_W'(1))    stateNext = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // The IV is written only on an accepted start. Every later block reuses
  // it, so the IV bits never change inside a message, even across a wrap.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ivReg   <= '0;
      ctr     <= '0;
      remCnt  <= '0;
      wrapReg <= 1'b0;
    end else if (startOk) begin
      ivReg   <= iIV;
      remCnt  <= iNumBlk;
      ctr     <= CTR_W'(1);
      wrapReg <= 1'b0;
    end else if (xfer && !iAbort) begin
      if (state == J0) begin
        if (remCnt != '0) ctr <= CTR_W'(2);
      end else begin
        // inc32: the counter field rolls over modulo 2^CTR_W.
        ctr    <= ctr + CTR_W'(1);
        remCnt <= remCnt - LEN_W'(1);
        if (ctr == '1) wrapReg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcm_icb_sequencer.sv
module tb_gcm_icb_sequencer;
  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iStart = 1'b0;
  logic          iAbort = 1'b0;
  logic          iCB_ready = 1'b0;
  logic [0:95]   iIV = '0;
  logic [15:0]   iNumBlk = '0;
  logic [0:127]  oCB;
  logic          oCB_valid, oIsJ0, oLast, oBusy, oDone, oWrap;

  int errors = 0;
  int checks = 0;

  always #5 iClk = ~iClk;

  gcm_icb_sequencer dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
    .iIV(iIV), .iNumBlk(iNumBlk), .oCB(oCB), .oCB_valid(oCB_valid),
    .iCB_ready(iCB_ready), .oIsJ0(oIsJ0), .oLast(oLast), .oBusy(oBusy),
    .oDone(oDone), .oWrap(oWrap)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start expands into the complete list of
  // blocks the message must produce. Each accepted block is popped off.
  logic [127:0] mQ[$];
  bit           mJ0[$];
  bit           mLast[$];
  bit           mActive = 0;
  bit           mDone = 0;
  bit           mWrap = 0;
  bit           mRstZ = 0;
  bit           started = 0;

  task automatic modelClear();
    mQ.delete(); mJ0.delete(); mLast.delete();
    mActive = 0;
  endtask

  always @(posedge iClk) begin
    started = 1;
    mRstZ = iRst;
    if (iRst) begin
      modelClear();
      mDone = 0;
      mWrap = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mActive) begin
      if (iAbort) begin
        modelClear();
      end else if (iCB_ready) begin
        if (!mJ0[0] && mQ[0][31:0] == 32'hFFFF_FFFF) mWrap = 1;
        void'(mQ.pop_front());
        void'(mJ0.pop_front());
        void'(mLast.pop_front());
        if (mQ.size() == 0) begin
          mActive = 0;
          mDone = 1;
        end
      end
    end else if (iStart && !iAbort) begin
      mQ.push_back({iIV, 32'd1});
      mJ0.push_back(1'b1);
      mLast.push_back(iNumBlk == 16'd0);
      for (int k = 0; k < int'(iNumBlk); k++) begin
        mQ.push_back({iIV, 32'(k + 2)});
        mJ0.push_back(1'b0);
        mLast.push_back(k == int'(iNumBlk) - 1);
      end
      mActive = 1;
      mWrap = 0;
    end
  end

  always @(negedge iClk) begin
    if (started) begin
      check1("valid", oCB_valid, mActive);
      check1("busy", oBusy, mActive);
      check1("done", oDone, mDone);
      check1("wrap", oWrap, mWrap);
      if (mActive) begin
        check128("cb", oCB, mQ[0]);
        check1("isJ0", oIsJ0, mJ0[0]);
        check1("last", oLast, mLast[0]);
      end else begin
        check1("isJ0_idle", oIsJ0, 1'b0);
        check1("last_idle", oLast, 1'b0);
      end
      if (mRstZ) check128("cb_reset", oCB, 128'd0);
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic startSeq(input logic [95:0] iv, input logic [15:0] n);
    iIV = iv;
    iNumBlk = n;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (oDone) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: oDone got 0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  localparam logic [95:0] IV1 = 96'hCAFEBABEFACEDBADDECAF888;
  localparam logic [95:0] IV2 = 96'h0123456789ABCDEF01234567;
  localparam logic [95:0] IV3 = 96'hA5A5A5A55A5A5A5AFFFF0000;
  localparam logic [95:0] IV4 = 96'h111122223333444455556666;
  localparam logic [95:0] IV5 = 96'hDEADBEEF0000000012345678;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] tmp;
    int k;

    repeat (3) tick();
    iRst = 1'b0;
    check128("rst_cb", oCB, 128'd0);
    check1("rst_valid", oCB_valid, 1'b0);
    check1("rst_busy", oBusy, 1'b0);
    check1("rst_wrap", oWrap, 1'b0);
    tick();

    // 1: three data blocks streamed back to back
    iCB_ready = 1'b1;
    startSeq(IV1, 16'd3);
    check128("t1_j0", oCB, 128'hCAFEBABEFACEDBADDECAF888_00000001);
    check1("t1_isj0", oIsJ0, 1'b1);
    tick();
    check128("t1_c2", oCB, 128'hCAFEBABEFACEDBADDECAF888_00000002);
    tick();
    check128("t1_c3", oCB, 128'hCAFEBABEFACEDBADDECAF888_00000003);
    tick();
    check128("t1_c4", oCB, 128'hCAFEBABEFACEDBADDECAF888_00000004);
    check1("t1_last", oLast, 1'b1);
    tick();
    check1("t1_done", oDone, 1'b1);
    iStart = 1'b1;          // start during DONE is ignored
    tick();
    iStart = 1'b0;
    check1("t1_done_clr", oDone, 1'b0);
    check1("t1_ign_start", oCB_valid, 1'b0);
    tick();

    // 2: J0 only
    startSeq(IV2, 16'd0);
    check1("t2_isj0", oIsJ0, 1'b1);
    check1("t2_last", oLast, 1'b1);
    tick();
    check1("t2_done", oDone, 1'b1);
    tick();
    check1("t2_no_c2", oCB_valid, 1'b0);
    tick();

    // 3: backpressure with ready pattern 1,0,0,1
    startSeq(IV2, 16'd4);
    for (int i = 0; i < 40; i++) begin
      if (oDone) break;
      iCB_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    waitDone("t3_done", 4);
    iCB_ready = 1'b1;
    tick(); tick();

    // 4: counter wrap, with the counter preloaded through the hierarchy
    iCB_ready = 1'b0;
    startSeq(IV3, 16'd5);
    iCB_ready = 1'b1;
    tick();
    iCB_ready = 1'b0;
    force dut.ctr = 32'hFFFF_FFFE;
    #1;
    release dut.ctr;
    k = 0;
    for (int i = 0; i < mQ.size(); i++) begin
      if (!mJ0[i]) begin
        tmp = mQ[i];
        tmp[31:0] = 32'hFFFF_FFFE + 32'(k);
        mQ[i] = tmp;
        k++;
      end
    end
    tick();
    check128("t4_fe", oCB, {IV3, 32'hFFFF_FFFE});
    iCB_ready = 1'b1;
    tick();
    check128("t4_ff", oCB, {IV3, 32'hFFFF_FFFF});
    check1("t4_nowrap", oWrap, 1'b0);
    tick();
    check128("t4_00", oCB, {IV3, 32'h0000_0000});
    check1("t4_wrap", oWrap, 1'b1);
    waitDone("t4_done", 10);
    tick();
    check1("t4_wrap_hold", oWrap, 1'b1);
    tick();

    // 5: abort while ctr=5 is offered, then restart
    startSeq(IV4, 16'd8);
    for (int i = 0; i < 20; i++) begin
      if (mActive && !mJ0[0] && mQ[0][31:0] == 32'd5) break;
      tick();
    end
    check128("t5_at5", oCB, {IV4, 32'd5});
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check1("t5_abort_valid", oCB_valid, 1'b0);
    check1("t5_abort_done", oDone, 1'b0);
    tick();
    iAbort = 1'b1;
    iStart = 1'b1;
    tick();
    iAbort = 1'b0;
    iStart = 1'b0;
    check1("t5_abort_wins", oCB_valid, 1'b0);
    startSeq(IV5, 16'd1);
    check128("t5_restart", oCB, {IV5, 32'd1});
    check1("t5_wrap_clr", oWrap, 1'b0);
    waitDone("t5_done", 10);
    tick();

    // 6: start while busy, reset mid-DATA, reset together with start
    iCB_ready = 1'b0;
    startSeq(IV5, 16'd3);
    iCB_ready = 1'b1;
    tick();
    iIV = IV1;
    iNumBlk = 16'd9;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check128("t6_ignore", oCB, {IV5, 32'd3});
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check128("t6_rst_cb", oCB, 128'd0);
    check1("t6_rst_valid", oCB_valid, 1'b0);
    check1("t6_rst_busy", oBusy, 1'b0);
    iRst = 1'b1;
    iStart = 1'b1;
    tick();
    iRst = 1'b0;
    iStart = 1'b0;
    check1("t6_rst_wins", oCB_valid, 1'b0);
    tick();
    check1("t6_still_idle", oBusy, 1'b0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
